// File: rtl/gps_ca_pkg.sv
// Shared constants, G2 tap table and FSM state type for the C/A capture engine.
package gps_ca_pkg;

    localparam int unsigned CA_PERIOD = 1023;
    localparam int unsigned LFSR_W    = 10;

    // Bit i of a register holds LFSR stage i+1; stage 10 (bit 9) is the output.
    localparam logic [LFSR_W-1:0] G1_FB_MASK = 10'h204;  // stages 3,10
    localparam logic [LFSR_W-1:0] G2_FB_MASK = 10'h3A6;  // stages 2,3,6,8,9,10
    localparam logic [LFSR_W-1:0] LFSR_INIT  = '1;

    typedef struct packed {
        logic [3:0] t1;
        logic [3:0] t2;
    } g2_taps_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_CAPTURE,
        ST_HOLD
    } ca_state_t;

    function automatic logic prn_valid(input logic [5:0] prn);
        return (prn >= 6'd1) && (prn <= 6'd37);
    endfunction

    // G2 phase-selector taps (stage numbers) for PRN 1..37.
    function automatic g2_taps_t prn_taps(input logic [5:0] prn);
        g2_taps_t t;
        case (prn)
            6'd1:  t = {4'd2, 4'd6};
            6'd2:  t = {4'd3, 4'd7};
            6'd3:  t = {4'd4, 4'd8};
            6'd4:  t = {4'd5, 4'd9};
            6'd5:  t = {4'd1, 4'd9};
            6'd6:  t = {4'd2, 4'd10};
            6'd7:  t = {4'd1, 4'd8};
            6'd8:  t = {4'd2, 4'd9};
            6'd9:  t = {4'd3, 4'd10};
            6'd10: t = {4'd2, 4'd3};
            6'd11: t = {4'd3, 4'd4};
            6'd12: t = {4'd5, 4'd6};
            6'd13: t = {4'd6, 4'd7};
            6'd14: t = {4'd7, 4'd8};
            6'd15: t = {4'd8, 4'd9};
            6'd16: t = {4'd9, 4'd10};
            6'd17: t = {4'd1, 4'd4};
            6'd18: t = {4'd2, 4'd5};
            6'd19: t = {4'd3, 4'd6};
            6'd20: t = {4'd4, 4'd7};
            6'd21: t = {4'd5, 4'd8};
            6'd22: t = {4'd6, 4'd9};
            6'd23: t = {4'd1, 4'd3};
            6'd24: t = {4'd4, 4'd6};
            6'd25: t = {4'd5, 4'd7};
            6'd26: t = {4'd6, 4'd8};
            6'd27: t = {4'd7, 4'd9};
            6'd28: t = {4'd8, 4'd10};
            6'd29: t = {4'd1, 4'd6};
            6'd30: t = {4'd2, 4'd7};
            6'd31: t = {4'd3, 4'd8};
            6'd32: t = {4'd4, 4'd9};
            6'd33: t = {4'd5, 4'd10};
            6'd34: t = {4'd4, 4'd10};
            6'd35: t = {4'd1, 4'd7};
            6'd36: t = {4'd2, 4'd8};
            6'd37: t = {4'd4, 4'd10};
            default: t = {4'd1, 4'd1};  // invalid PRN; chip is masked by the top
        endcase
        return t;
    endfunction

endpackage

// File: rtl/gps_ca_multi_lfsr.sv
// One channel's G1/G2 Gold-code generator with load-to-ones and single-chip advance.
module gps_ca_lfsr
    import gps_ca_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     adv,
    input  g2_taps_t taps,
    output logic     chip
);

    logic [LFSR_W-1:0] g1;
    logic [LFSR_W-1:0] g2;
    logic [3:0]        i1;
    logic [3:0]        i2;

    // Both registers shift toward stage 10; load wins over advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1 <= LFSR_INIT;
            g2 <= LFSR_INIT;
        end else if (load) begin
            g1 <= LFSR_INIT;
            g2 <= LFSR_INIT;
        end else if (adv) begin
            g1 <= {g1[LFSR_W-2:0], ^(g1 & G1_FB_MASK)};
            g2 <= {g2[LFSR_W-2:0], ^(g2 & G2_FB_MASK)};
        end
    end

    // Current chip from G1 output and the two selected G2 stages.
    always_comb begin
        i1   = taps.t1 - 4'd1;
        i2   = taps.t2 - 4'd1;
        chip = g1[LFSR_W-1] ^ g2[i1] ^ g2[i2];
    end

endmodule

// File: rtl/gps_ca_multi.sv
// Multi-channel C/A capture engine: shared FSM, chip divider and capture registers.
module gps_ca_multi
    import gps_ca_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CA_BITS  = 13,
    parameter int unsigned CHIP_DIV = 4
) (
    input  logic                        sys_clk_50,
    input  logic                        sync_rst_in,
    input  logic                        start,
    input  logic [6*NUM_CH-1:0]         sv_num,
    input  logic [9:0]                  code_phase,
    input  logic                        code_ready,
    output logic                        busy,
    output logic                        code_valid,
    output logic [CA_BITS*NUM_CH-1:0]   ca_code,
    output logic [NUM_CH-1:0]           sv_err
);

    ca_state_t state;
    ca_state_t state_nxt;

    logic                      start_r;
    logic [6*NUM_CH-1:0]       sv_r;
    logic [9:0]                phase_r;
    logic [9:0]                phase_in;
    logic [9:0]                chip_idx;
    logic [9:0]                bit_cnt;
    logic [7:0]                div;
    logic                      accept;
    logic                      chip_tick;
    logic                      adv;
    logic                      wrap;
    logic                      load;
    logic                      seek_done;
    logic                      last_bit;
    logic [NUM_CH-1:0]         sv_bad;
    logic [NUM_CH-1:0]         chip;
    logic [NUM_CH-1:0]         chip_m;
    logic [CA_BITS*NUM_CH-1:0] capture_nxt;

    // Control strobes derived from the current state and counters.
    always_comb begin
        phase_in  = (code_phase > 10'd1022) ? 10'd1022 : code_phase;
        accept    = (state == ST_IDLE) && start && !start_r;
        chip_tick = (div == 8'(CHIP_DIV - 1));
        adv       = (state == ST_SEEK) || ((state == ST_CAPTURE) && chip_tick);
        // Reloading at the epoch end equals the free-running state after 1023 shifts.
        wrap      = adv && (chip_idx == 10'(CA_PERIOD - 1));
        load      = accept || wrap;
        seek_done = (chip_idx == phase_r - 10'd1);
        last_bit  = (bit_cnt == 10'(CA_BITS - 1));
    end

    // Per-channel PRN check and next capture value (shift chip into slice LSB).
    always_comb begin
        sv_bad      = '0;
        capture_nxt = '0;
        chip_m      = chip & ~sv_err;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            sv_bad[k] = !prn_valid(sv_num[6*k +: 6]);
            capture_nxt[CA_BITS*k +: CA_BITS] =
                CA_BITS'({ca_code[CA_BITS*k +: CA_BITS], chip_m[k]});
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        g2_taps_t taps_k;
        assign taps_k = prn_taps(sv_r[6*k +: 6]);

        gps_ca_lfsr u_lfsr (
            .clk  (sys_clk_50),
            .rst  (sync_rst_in),
            .load (load),
            .adv  (adv),
            .taps (taps_k),
            .chip (chip[k])
        );
    end

    // FSM state register.
    always_ff @(posedge sys_clk_50 or posedge sync_rst_in) begin
        if (sync_rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt  = state;
        busy       = (state != ST_IDLE);
        code_valid = (state == ST_HOLD);
        case (state)
            ST_IDLE:    if (accept) state_nxt = (phase_in != 10'd0) ? ST_SEEK : ST_CAPTURE;
            ST_SEEK:    if (seek_done) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (chip_tick && last_bit) state_nxt = ST_HOLD;
            ST_HOLD:    if (code_ready) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Edge tracking, round parameters, counters and capture registers.
    always_ff @(posedge sys_clk_50 or posedge sync_rst_in) begin
        if (sync_rst_in) begin
            start_r  <= 1'b0;
            sv_r     <= '0;
            phase_r  <= '0;
            sv_err   <= '0;
            chip_idx <= '0;
            bit_cnt  <= '0;
            div      <= '0;
            ca_code  <= '0;
        end else begin
            start_r <= start;
            if (accept) begin
                sv_r     <= sv_num;
                phase_r  <= phase_in;
                sv_err   <= sv_bad;
                chip_idx <= '0;
                bit_cnt  <= '0;
                div      <= '0;
            end else begin
                if (adv) begin
                    chip_idx <= wrap ? 10'd0 : chip_idx + 10'd1;
                end
                if (state == ST_CAPTURE) begin
                    div <= chip_tick ? 8'd0 : div + 8'd1;
                    if (chip_tick) begin
                        bit_cnt <= bit_cnt + 10'd1;
                        ca_code <= capture_nxt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gps_ca_multi.sv
// Scoreboard bench for gps_ca_multi with a chip-sequence reference model.
module tb_gps_ca_multi;

    localparam int NCH  = 4;
    localparam int CAB  = 13;
    localparam int CDIV = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 ready = 1'b0;
    logic [6*NCH-1:0]     sv = '0;
    logic [9:0]           phase = '0;
    logic                 busy;
    logic                 valid;
    logic [CAB*NCH-1:0]   ca_code;
    logic [NCH-1:0]       sv_err;

    gps_ca_multi #(.NUM_CH(NCH), .CA_BITS(CAB), .CHIP_DIV(CDIV)) dut (
        .sys_clk_50  (clk),
        .sync_rst_in (rst),
        .start       (start),
        .sv_num      (sv),
        .code_phase  (phase),
        .code_ready  (ready),
        .busy        (busy),
        .code_valid  (valid),
        .ca_code     (ca_code),
        .sv_err      (sv_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CAB*NCH-1:0] code;
        logic [NCH-1:0]     err;
        int                 at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // ICD phase-selector table, PRN index 1..37.
    int t1_tab[38] = '{0, 2,3,4,5,1,2,1,2,3,2, 3,5,6,7,8,9,1,2,3,4,
                       5,6,1,4,5,6,7,8,1,2, 3,4,5,4,1,2,4};
    int t2_tab[38] = '{0, 6,7,8,9,9,10,8,9,10,3, 4,6,7,8,9,10,4,5,6,7,
                       8,9,3,6,7,8,9,10,6,7, 8,9,10,10,7,8,10};
    bit seq[38][1023];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Full 1023-chip sequence per PRN from the textbook G1/G2 description.
    task automatic build_model();
        bit a[11];
        bit b[11];
        bit fa, fb;
        for (int p = 1; p <= 37; p++) begin
            for (int s = 1; s <= 10; s++) begin a[s] = 1'b1; b[s] = 1'b1; end
            for (int n = 0; n < 1023; n++) begin
                seq[p][n] = a[10] ^ b[t1_tab[p]] ^ b[t2_tab[p]];
                fa = a[3] ^ a[10];
                fb = b[2] ^ b[3] ^ b[6] ^ b[8] ^ b[9] ^ b[10];
                for (int s = 10; s >= 2; s--) begin a[s] = a[s-1]; b[s] = b[s-1]; end
                a[1] = fa;
                b[1] = fb;
            end
        end
    endtask

    function automatic logic [CAB*NCH-1:0] expect_code(input logic [6*NCH-1:0] s, input int ph);
        logic [CAB*NCH-1:0] c = '0;
        int p;
        for (int k = 0; k < NCH; k++) begin
            p = int'(s[6*k +: 6]);
            if (p >= 1 && p <= 37)
                for (int i = 0; i < CAB; i++)
                    c[CAB*k + CAB-1-i] = seq[p][(ph + i) % 1023];
        end
        return c;
    endfunction

    function automatic logic [NCH-1:0] expect_err(input logic [6*NCH-1:0] s);
        logic [NCH-1:0] e = '0;
        int p;
        for (int k = 0; k < NCH; k++) begin
            p = int'(s[6*k +: 6]);
            e[k] = !(p >= 1 && p <= 37);
        end
        return e;
    endfunction

    // Called at posedge+1 with start low; produces an edge at the next posedge (E0).
    task automatic issue(input logic [6*NCH-1:0] s, input logic [9:0] ph);
        exp_t e;
        int   pe;
        pe     = (ph > 10'd1022) ? 1022 : int'(ph);
        sv     = s;
        phase  = ph;
        start  = 1'b1;
        e.code = expect_code(s, pe);
        e.err  = expect_err(s);
        e.at   = cyc + 1 + pe + CAB * CDIV;
        sb.push_back(e);
        @(posedge clk); #1;
        chk("busy_after_start", 64'(busy), 64'd1);
        start = 1'b0;
        sv    = 24'($urandom);
        phase = 10'($urandom);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_timeout", 64'(valid), 64'd1);
    endtask

    task automatic handshake(input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, 64'(valid), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_code"}, 64'(ca_code), 64'd0);
        chk({name, "_err"}, 64'(sv_err), 64'd0);
    endtask

    // Monitor: pops on each new result, then enforces hold/release behaviour.
    logic               prev_v = 1'b0;
    logic               prev_r = 1'b0;
    logic [CAB*NCH-1:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v) begin
                if (prev_r) begin
                    chk("release_valid", 64'(valid), 64'd0);
                    chk("release_busy", 64'(busy), 64'd0);
                end else begin
                    chk("hold_valid", 64'(valid), 64'd1);
                    chk("hold_code", 64'(ca_code), 64'(held));
                end
            end else if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=none", ca_code);
                end else begin
                    e = sb.pop_front();
                    chk("ca_code", 64'(ca_code), 64'(e.code));
                    chk("sv_err", 64'(sv_err), 64'(e.err));
                    chk("latency", 64'(cyc), 64'(e.at));
                    chk("busy_in_hold", 64'(busy), 64'd1);
                end
                held = ca_code;
            end
            prev_v = valid;
            prev_r = ready;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6*NCH-1:0] s;
        build_model();

        // Asynchronous reset asserted mid-cycle.
        #12 rst = 1'b1;
        #1 check_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // PRN 1..4, phase 0: known first ten chips of each code.
        issue({6'd4, 6'd3, 6'd2, 6'd1}, 10'd0);
        wait_valid();
        chk("prn1_chips", 64'(ca_code[12:3]),  64'(10'b1100100000));
        chk("prn2_chips", 64'(ca_code[25:16]), 64'(10'b1110010000));
        chk("prn3_chips", 64'(ca_code[38:29]), 64'(10'b1111001000));
        chk("prn4_chips", 64'(ca_code[51:42]), 64'(10'b1111100100));
        handshake(0);

        // Epoch wrap: chips 3..9 of the capture are the epoch start.
        issue({6'd7, 6'd20, 6'd33, 6'd1}, 10'd1020);
        wait_valid();
        chk("wrap_chips", 64'(ca_code[9:3]), 64'(7'b1100100));
        handshake(2);

        // Phase 1023 behaves as 1022.
        issue({6'd37, 6'd12, 6'd5, 6'd9}, 10'd1023);
        wait_valid();
        handshake(1);

        // Long hold with a start pulse that must be ignored.
        issue({6'd11, 6'd22, 6'd30, 6'd2}, 10'd5);
        wait_valid();
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        handshake(14);
        repeat (3) begin
            chk("pulse_ignored", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end

        // Invalid PRNs on channels 0 and 1.
        issue({6'd37, 6'd5, 6'd38, 6'd0}, 10'd3);
        wait_valid();
        chk("err_flags", 64'(sv_err), 64'(4'b0011));
        chk("err_slices", 64'(ca_code[25:0]), 64'd0);
        handshake(0);

        // Reset during CAPTURE aborts the round.
        issue({6'd8, 6'd16, 6'd24, 6'd32}, 10'd0);
        repeat (20) @(posedge clk);
        #4 rst = 1'b1;
        #1 check_zero("abort");
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Randomised rounds.
        for (int r = 0; r < 16; r++) begin
            for (int k = 0; k < NCH; k++)
                s[6*k +: 6] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                          : 6'($urandom_range(1, 37));
            issue(s, (r % 3 == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 40)));
            wait_valid();
            handshake($urandom_range(0, 4));
        end

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gps_ca_multi.md
# gps_ca_multi

Parametrised, multi-channel C/A-code capture engine. Replaces the dual-clock, single-satellite C/A path with a single-clock design. It runs NUM_CH Gold-code generators in lockstep, each with its own SV number. Chip rate comes from a clock-enable divider rather than a derived clock. A programmable code-phase offset selects the chips to capture, and results are delivered over a valid/ready handshake. Sits in the GPS core next to the P-code/AES path and feeds the register interface.

## Interface
- NUM_CH, 4, number of parallel satellite channels (1..8)
- CA_BITS, 13, chips captured per channel per round (1..1023)
- CHIP_DIV, 4, sys_clk_50 cycles per chip (1..255)
- sys_clk_50  in  1  sole clock; all logic on rising edge
- sync_rst_in  in  1  reset, asynchronous, active-high
- start  in  1  rising edge requests a capture round
- sv_num  in  6*NUM_CH  PRN per channel, channel k in bits [6k+5:6k]
- code_phase  in  10  chips skipped before capture (0..1022; values ≥1023 treated as 1022)
- code_ready  in  1  consumer accepts result
- busy  out  1  high from start acceptance until handshake completes
- code_valid  out  1  results stable and valid
- ca_code  out  CA_BITS*NUM_CH  captured chips, channel k in [CA_BITS*k+CA_BITS-1 : CA_BITS*k], first chip in MSB
- sv_err  out  NUM_CH  channel's latched sv_num outside 1..37

## Operation
- start_r register; edge = start & ~start_r. Edges are acted on only in IDLE; elsewhere they are discarded, because start_r keeps tracking.
- FSM: IDLE → SEEK → CAPTURE → HOLD → IDLE.
  - IDLE + edge: latch sv_num/code_phase, set sv_err, load all LFSRs G1=G2=10'h3FF, chip_idx=0, div=0. Next state is SEEK if phase≠0, else CAPTURE.
  - SEEK: advance every LFSR one chip per clock (no divider) and chip_idx++. Exit to CAPTURE after code_phase advances.
  - CAPTURE: div counts 0..CHIP_DIV-1. At div==CHIP_DIV-1, shift the current chip into each channel's slice LSB (earlier bits move toward MSB), advance the LFSRs, chip_idx++ and bit_cnt++. Exit to HOLD after the CA_BITS-th shift.
  - HOLD: code_valid=1. On code_valid & code_ready, go to IDLE and drop busy and code_valid.
- Chip = G1[10] ^ G2[t1] ^ G2[t2], using per-PRN taps from the package table.
  - G1 feedback: taps 3,10.
  - G2 feedback: taps 2,3,6,8,9,10.
- Epoch wrap: when chip_idx==1022 advances, reload LFSRs to all-ones and set chip_idx=0. This must be bit-identical to free running.
- sv_err channels: chip forced 0, so the channel slice captures all zeros. The other channels are unaffected.
- ca_code holds its last value in IDLE and is overwritten only by the next CAPTURE.
- Reset (any state, asynchronous): FSM=IDLE; busy, code_valid, ca_code, sv_err, start_r and all counters = 0; LFSRs = all-ones.

## Timing
- Start edge detected at edge E0: busy=1 after E0. code_valid=1 after edge E0 + phase + CA_BITS·CHIP_DIV.
- Defaults with phase 0: valid 52 cycles after E0.
- Handshake completes at the edge where valid&ready are both high; busy and valid are 0 after that edge.
- Earliest next accepted start edge is the cycle after the return to IDLE.
- code_valid never drops without a handshake.
- Counter widths: div 8b, bit_cnt 10b, chip_idx 10b.

## Structure
- Package gps_ca_pkg holds:
  - CA_PERIOD=1023, LFSR width 10, G1/G2 feedback masks.
  - G2 tap table (t1,t2) for PRN 1..37, e.g. PRN1 (2,6), PRN2 (3,7), PRN3 (4,8), PRN4 (5,9).
  - FSM state enum.
- Sub-module gps_ca_lfsr, one per channel. Ports: load, adv, taps, chip out.
- Top level holds the shared FSM, counters, edge detect and capture registers.

## Test plan
- Reset: assert sync_rst_in asynchronously mid-cycle → all outputs 0 immediately; FSM idle.
- Single PRN: defaults, sv0=1, phase 0, start edge → valid after 52 cycles; ca_code[12:3] = 10'b1100100000.
- Multi-channel: sv=1,2,3,4, CA_BITS=10, CHIP_DIV=1 → slices 1100100000, 1110010000, 1111001000, 1111100100; valid 10 cycles after E0.
- Wrap: PRN1, CA_BITS=10, phase 1020 → low 7 bits 1100100; valid after 1020+10·CHIP_DIV cycles.
- Handshake: hold code_ready=0 for 20 cycles with a start pulse in between → valid/busy stay 1, result unchanged, pulse ignored. Raise ready → idle next cycle; a fresh start then completes normally.
- Errors/abort: sv0=0 and sv1=38 → sv_err=2'b11, those slices zero, others correct. Reset during CAPTURE → outputs 0, and the next round is correct.
